// File: rtl/alu_pkg.sv
// Shared ALU definitions: result-mux select codes, sequencer state encoding
// and the request header carried through the request FIFO.
package alu_pkg;

    // Select codes shared with the result multiplexer
    localparam logic [2:0] SEL_XFER = 3'd0;
    localparam logic [2:0] SEL_ADD  = 3'd1;
    localparam logic [2:0] SEL_GATE = 3'd2;
    localparam logic [2:0] SEL_CMP  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_STROBE = 2'd3
    } seq_state_t;

    // Request header; operands follow it in the FIFO word as {hdr, A, B}
    typedef struct packed {
        logic [2:0] code;
        logic [1:0] func;
    } alu_op_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO, power-of-two depth, registered count.
// Ports: i_clk/i_rst_n (async active-low), i_push/i_data write side,
// i_pop/o_data read side (o_data shows the head), o_full/o_empty/o_count.
// Push while full and pop while empty are ignored.
module alu_req_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_data,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; pointers define validity
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU request front-end. Buffers requests, issues operands/function/Select
// to the functional units, waits the unit latency and strobes Flag for one
// cycle so the result mux captures. Illegal codes (4..7) pulse Illegal only.
// Ports: Clk, Reset (async active-low); Op_* request handshake; Unit_A/B,
// Unit_Func, Select to units/mux; Flag, Illegal pulses; Busy; Op_Count.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int LAT_XFER   = 1,
    parameter int LAT_ADD    = 2,
    parameter int LAT_GATE   = 1,
    parameter int LAT_CMP    = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Op_Valid,
    output logic             Op_Ready,
    input  logic [2:0]       Op_Code,
    input  logic [1:0]       Op_Func,
    input  logic [WIDTH-1:0] Op_A,
    input  logic [WIDTH-1:0] Op_B,
    output logic [WIDTH-1:0] Unit_A,
    output logic [WIDTH-1:0] Unit_B,
    output logic [1:0]       Unit_Func,
    output logic [2:0]       Select,
    output logic             Flag,
    output logic             Illegal,
    output logic             Busy,
    output logic [7:0]       Op_Count
);
    localparam int DW = 5 + 2*WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DW-1:0]    w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_pop;
    logic [3:0]       w_lat;

    seq_state_t       r_state;
    alu_op_t          r_op;      // head captured on pop, issued in LOAD
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_unit_a;
    logic [WIDTH-1:0] r_unit_b;
    logic [1:0]       r_unit_func;
    logic [2:0]       r_select;
    logic             r_flag;
    logic             r_illegal;
    logic [7:0]       r_op_count;

    alu_req_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_push  (Op_Valid),
        .i_data  ({Op_Code, Op_Func, Op_A, Op_B}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Every path into LOAD pops: from IDLE, from STROBE, or after an illegal LOAD
    assign w_pop = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_STROBE) ||
                                ((r_state == ST_LOAD) && r_op.code[2]));

    always_comb begin
        w_lat = 4'd1;
        case (r_op.code)
            SEL_XFER: w_lat = 4'(LAT_XFER);
            SEL_ADD:  w_lat = 4'(LAT_ADD);
            SEL_GATE: w_lat = 4'(LAT_GATE);
            SEL_CMP:  w_lat = 4'(LAT_CMP);
            default:  w_lat = 4'd1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_unit_a    <= '0;
            r_unit_b    <= '0;
            r_unit_func <= '0;
            r_select    <= '0;
            r_flag      <= 1'b0;
            r_illegal   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            // Flag follows STROBE by one edge so it lands LAT cycles after issue
            r_flag    <= (r_state == ST_STROBE);
            r_illegal <= 1'b0;
            if (w_pop) begin
                {r_op, r_a, r_b} <= w_head;
                // Illegal is known at pop time, so the pulse covers the LOAD cycle
                r_illegal        <= w_head[DW-1];
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (r_op.code[2]) begin
                        r_state <= w_empty ? ST_IDLE : ST_LOAD;
                    end else begin
                        r_unit_a    <= r_a;
                        r_unit_b    <= r_b;
                        r_unit_func <= r_op.func;
                        r_select    <= r_op.code;
                        r_cnt       <= w_lat - 4'd1;
                        r_state     <= (w_lat <= 4'd1) ? ST_STROBE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    r_op_count <= r_op_count + 8'd1;
                    r_state    <= w_empty ? ST_IDLE : ST_LOAD;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Op_Ready  = !w_full;
    assign Unit_A    = r_unit_a;
    assign Unit_B    = r_unit_b;
    assign Unit_Func = r_unit_func;
    assign Select    = r_select;
    assign Flag      = r_flag;
    assign Illegal   = r_illegal;
    assign Op_Count  = r_op_count;
    assign Busy      = (r_state != ST_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Op_Valid = 1'b0;
    logic       Op_Ready;
    logic [2:0] Op_Code = '0;
    logic [1:0] Op_Func = '0;
    logic [7:0] Op_A = '0, Op_B = '0;
    logic [7:0] Unit_A, Unit_B;
    logic [1:0] Unit_Func;
    logic [2:0] Select;
    logic       Flag, Illegal, Busy;
    logic [7:0] Op_Count;

    alu_op_sequencer #(.WIDTH(8), .FIFO_DEPTH(2), .LAT_XFER(1), .LAT_ADD(2),
                       .LAT_GATE(1), .LAT_CMP(1)) dut (
        .Clk(Clk), .Reset(Reset), .Op_Valid(Op_Valid), .Op_Ready(Op_Ready),
        .Op_Code(Op_Code), .Op_Func(Op_Func), .Op_A(Op_A), .Op_B(Op_B),
        .Unit_A(Unit_A), .Unit_B(Unit_B), .Unit_Func(Unit_Func), .Select(Select),
        .Flag(Flag), .Illegal(Illegal), .Busy(Busy), .Op_Count(Op_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] code;
        logic [1:0] func;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t       exp_q[$];
    int         flag_times[$];
    int         total = 0, bad = 0, cyc = 0, ill_pending = 0;
    logic [7:0] exp_cnt = '0;
    logic [2:0] last_sel = '0;
    logic       prev_flag = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge Clk) cyc++;

    // Scoreboard: every Flag must match the oldest accepted legal request
    always @(negedge Clk) begin
        if (!Reset) begin
            prev_flag = 1'b0;
        end else begin
            if (Flag) begin
                exp_t e;
                flag_times.push_back(cyc);
                chk("flag_width", prev_flag, 0);
                if (exp_q.size() == 0) chk("flag_unexp", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    exp_cnt++;
                    chk("sb_sel", Select, e.code);
                    chk("sb_a", Unit_A, e.a);
                    chk("sb_b", Unit_B, e.b);
                    chk("sb_func", Unit_Func, e.func);
                    chk("sb_cnt", Op_Count, exp_cnt);
                    last_sel = e.code;
                end
            end
            if (Illegal) begin
                if (ill_pending == 0) chk("ill_unexp", 1, 0);
                else begin
                    ill_pending--;
                    chk("ill_sel", Select, last_sel);
                    chk("ill_noflag_cnt", Op_Count, exp_cnt);
                end
            end
            prev_flag = Flag;
        end
    end

    task automatic chk_zero(input string p);
        chk({p, "_ua"}, Unit_A, 0);
        chk({p, "_ub"}, Unit_B, 0);
        chk({p, "_uf"}, Unit_Func, 0);
        chk({p, "_sel"}, Select, 0);
        chk({p, "_flag"}, Flag, 0);
        chk({p, "_ill"}, Illegal, 0);
        chk({p, "_busy"}, Busy, 0);
        chk({p, "_cnt"}, Op_Count, 0);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Op_Valid = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        last_sel = '0;
        ill_pending = 0;
        repeat (2) @(negedge Clk);
        chk_zero("rst");
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_ready", Op_Ready, 1);
    endtask

    // Holds the request until accepted; returns #1 after the accepting edge
    task automatic send(input logic [2:0] c, input logic [1:0] f,
                        input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        exp_t e;
        Op_Valid = 1'b1; Op_Code = c; Op_Func = f; Op_A = a; Op_B = b;
        while (!Op_Ready && n < 200) begin
            @(posedge Clk); #1; n++;
        end
        if (n >= 200) begin
            chk("send_timeout", 1, 0);
            Op_Valid = 1'b0;
            return;
        end
        @(posedge Clk);
        if (c[2]) ill_pending++;
        else begin
            e.code = c; e.func = f; e.a = a; e.b = b;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic drain(input string p);
        int n = 0;
        Op_Valid = 1'b0;
        while (Busy && n < 3000) begin
            @(negedge Clk); n++;
        end
        if (n >= 3000) chk({p, "_drain_timeout"}, 1, 0);
        repeat (3) @(negedge Clk);
        chk({p, "_sb_left"}, exp_q.size(), 0);
        chk({p, "_ill_left"}, ill_pending, 0);
        chk({p, "_cnt"}, Op_Count, exp_cnt);
    endtask

    initial begin
        // Single add: operands after E2, Flag after E4
        do_reset();
        send(3'd1, 2'd1, 8'h12, 8'h34);            // E0
        Op_Valid = 1'b0;
        @(posedge Clk); #1;                        // E1
        chk("t1_busy", Busy, 1);
        @(posedge Clk); #1;                        // E2
        chk("t1_sel", Select, 1);
        chk("t1_a", Unit_A, 8'h12);
        chk("t1_b", Unit_B, 8'h34);
        chk("t1_flag_e2", Flag, 0);
        @(posedge Clk); #1;                        // E3
        chk("t1_flag_e3", Flag, 0);
        @(posedge Clk); #1;                        // E4
        chk("t1_flag_e4", Flag, 1);
        chk("t1_cnt", Op_Count, 1);
        @(posedge Clk); #1;
        chk("t1_flag_e5", Flag, 0);
        drain("t1");

        // Three LAT=1 ops back-to-back: FIFO fills, Flags 2 cycles apart
        do_reset();
        flag_times.delete();
        send(3'd0, 2'd0, 8'h01, 8'hA1);
        send(3'd2, 2'd2, 8'h02, 8'hA2);
        send(3'd3, 2'd3, 8'h03, 8'hA3);
        chk("t2_ready_full", Op_Ready, 0);
        drain("t2");
        chk("t2_nflags", flag_times.size(), 3);
        if (flag_times.size() == 3) begin
            chk("t2_gap0", flag_times[1] - flag_times[0], 2);
            chk("t2_gap1", flag_times[2] - flag_times[1], 2);
        end
        chk("t2_cnt3", Op_Count, 3);

        // Illegal then transfer: one Illegal pulse, single Flag
        do_reset();
        send(3'd5, 2'd1, 8'h55, 8'h55);
        send(3'd0, 2'd0, 8'h66, 8'h77);
        drain("t3");
        chk("t3_cnt1", Op_Count, 1);
        // Illegal between legal ops must leave Select at the compare code
        send(3'd3, 2'd1, 8'h31, 8'h13);
        send(3'd7, 2'd3, 8'hEE, 8'hEE);
        send(3'd1, 2'd2, 8'h44, 8'h45);
        drain("t3b");

        // Counter wrap: 256 ops brings Op_Count back to 0
        do_reset();
        for (int i = 0; i < 255; i++) send(3'd0, 2'(i), 8'(i), 8'(~i));
        drain("t4a");
        chk("t4_cnt255", Op_Count, 255);
        send(3'd2, 2'd1, 8'hC3, 8'h3C);
        drain("t4b");
        chk("t4_wrap", Op_Count, 0);

        // Asynchronous reset during WAIT with one queued entry
        do_reset();
        @(negedge Clk);
        Op_Valid = 1'b1; Op_Code = 3'd1; Op_A = 8'hAA; Op_B = 8'h01;
        @(posedge Clk); #1;                        // E0
        Op_A = 8'hBB;
        @(posedge Clk); #1;                        // E1
        Op_Valid = 1'b0;
        @(posedge Clk); #1;                        // E2 -> WAIT
        chk("t5_pre_busy", Busy, 1);
        chk("t5_pre_a", Unit_A, 8'hAA);
        Reset = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        #1;
        chk_zero("t5");
        @(negedge Clk);
        Reset = 1'b1;
        repeat (12) @(negedge Clk);
        chk("t5_post_busy", Busy, 0);
        chk("t5_post_cnt", Op_Count, 0);
        chk("t5_post_ready", Op_Ready, 1);

        // Sustained pushes against a full FIFO: order kept, nothing lost/duplicated
        do_reset();
        for (int i = 0; i < 6; i++) send(3'd1, 2'(i), 8'h80 + 8'(i), 8'h40 - 8'(i));
        drain("t6");
        chk("t6_cnt", Op_Count, 6);

        // Random mix of codes and idle gaps
        do_reset();
        for (int i = 0; i < 30; i++) begin
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                Op_Valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge Clk);
                #1;
            end
        end
        drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
